// File: rtl/lift_pkg.sv
// Shared definitions for the lifting-scheme address sequencer:
// FSM state encoding, memory bank encoding and parameter defaults.
package lift_pkg;

    localparam int ADDR_W_DEFAULT = 12;
    localparam int LAT_DEFAULT    = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RUN   = 3'd1;
    localparam state_t ST_DRAIN = 3'd2;
    localparam state_t ST_SWAP  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam logic BANK_M1 = 1'b0;
    localparam logic BANK_M2 = 1'b1;

    // A transform needs an even level-0 length of at least one pair and a level count in range.
    function automatic logic params_ok(input int l0, input int lv, input int max_lv);
        return ((l0 % 2) == 0) && (l0 >= 2) && (lv >= 1) && (lv <= max_lv);
    endfunction

endpackage

// File: rtl/lift_delay_line.sv
// Fixed-latency shift register that carries {valid, n, Lk/2} from the read
// strobe to the matching write/detail strobe, 1+LAT cycles later.
module lift_delay_line
    import lift_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int LAT    = LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_n,
    input  logic [ADDR_W-1:0] in_half,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_n,
    output logic [ADDR_W-1:0] out_half
);

    localparam int DEPTH = 1 + LAT;

    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] n_q    [DEPTH];
    logic [ADDR_W-1:0] half_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                n_q[i]    <= '0;
                half_q[i] <= '0;
            end
        end else if (clear) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                n_q[i]    <= '0;
                half_q[i] <= '0;
            end
        end else if (en) begin
            valid_q[0] <= in_valid;
            n_q[0]     <= in_n;
            half_q[0]  <= in_half;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                n_q[i]     <= n_q[i-1];
                half_q[i]  <= half_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_n     = n_q[DEPTH-1];
    assign out_half  = half_q[DEPTH-1];

endmodule

// File: rtl/lifting_sequencer.sv
// Address/strobe sequencer for a multi-level lifting DWT ping-ponging between two banks.
// Optional feature: define LIFT_SEQ_STALL_EN to add a stall input that freezes the block.
module lifting_sequencer
    import lift_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int LAT        = LAT_DEFAULT,
    parameter int MAX_LEVELS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef LIFT_SEQ_STALL_EN
    input  logic              stall,
`endif
    input  logic              start,
    input  logic [ADDR_W-1:0] n_samples,
    input  logic [2:0]        levels,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic              bank_sel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              dn_valid,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [2:0]        level,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        fsm_state
);

    // Strobes are single-cycle qualifiers: address buses are meaningful only
    // while their strobe is high and read as zero otherwise; there is no back-pressure.
    logic active;
`ifdef LIFT_SEQ_STALL_EN
    assign active = ~stall;
`else
    assign active = 1'b1;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q, n_q, half, next_len;
    logic [2:0]        levels_q, level_q, next_level;
    logic              bank_q, err_q;
    logic              start_ok, finish_after_swap, dl_clear;
    logic              dl_valid;
    logic [ADDR_W-1:0] dl_n, dl_half;

    assign half       = len_q >> 1;
    assign next_len   = half;
    assign next_level = level_q + 3'd1;
    assign start_ok   = start && params_ok(int'(n_samples), int'(levels), MAX_LEVELS);

    // The next level is only possible on an even length of at least one pair.
    assign finish_after_swap = (next_level == levels_q) || next_len[0] ||
                               (next_len < ADDR_W'(2));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_RUN;
            ST_RUN:   if (n_q == half - ADDR_W'(1)) state_d = ST_DRAIN;
            ST_DRAIN: if (dl_valid && (dl_n == half - ADDR_W'(1))) state_d = ST_SWAP;
            ST_SWAP:  state_d = finish_after_swap ? ST_DONE : ST_RUN;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            n_q      <= '0;
            levels_q <= '0;
            level_q  <= '0;
            bank_q   <= BANK_M1;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (active) begin
                state_q <= state_d;
                case (state_q)
                    ST_IDLE: begin
                        if (start_ok) begin
                            len_q    <= n_samples;
                            levels_q <= levels;
                            level_q  <= '0;
                            bank_q   <= BANK_M1;
                            n_q      <= '0;
                        end else if (start) begin
                            err_q <= 1'b1;
                        end
                    end
                    ST_RUN:  n_q <= (state_d == ST_DRAIN) ? '0 : n_q + ADDR_W'(1);
                    ST_SWAP: begin
                        bank_q  <= (bank_q == BANK_M1) ? BANK_M2 : BANK_M1;
                        len_q   <= next_len;
                        level_q <= next_level;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dl_clear = active && (state_q != ST_RUN) && (state_d == ST_RUN);

    lift_delay_line #(
        .ADDR_W (ADDR_W),
        .LAT    (LAT)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (active),
        .clear     (dl_clear),
        .in_valid  (rd_en),
        .in_n      (n_q),
        .in_half   (half),
        .out_valid (dl_valid),
        .out_n     (dl_n),
        .out_half  (dl_half)
    );

    assign rd_en     = active && (state_q == ST_RUN);
    assign rd_addr_a = rd_en ? {n_q[ADDR_W-2:0], 1'b0} : '0;
    assign rd_addr_b = rd_en ? {n_q[ADDR_W-2:0], 1'b1} : '0;
    assign wr_en     = active && dl_valid;
    assign wr_addr   = wr_en ? dl_n : '0;
    assign dn_valid  = wr_en;
    assign dn_addr   = wr_en ? (dl_half + dl_n) : '0;
    assign bank_sel  = bank_q;
    assign level     = level_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = active && (state_q == ST_DONE);
    assign err       = err_q;
    assign fsm_state = state_q;

endmodule
